stdio_uart_tx: RTL
==================

// Module: stdio_uart_tx
// PURPOSE
//  Sink end of the stdio val/rdy stream: accepts 16-bit words from an stdio producer
//  (FIFO, CPU stdout port) and serializes each as two 8N1 UART frames on tx_o.
//  Connects the TOY machine's stdout to the board's UART TX pin.
//  Sequential datapath: bit-period counter, frame FSM, shift register, byte counter.
// PARAMETERS
//  CLKS_PER_BIT  434  clk_i cycles per UART bit (50 MHz / 115200); elaboration error if < 2
// PORTS
//  clk_i        in   1   single clock; all state updates on posedge
//  rst_ni       in   1   synchronous reset, active-low
//  stdin.val    in   1   producer has a word (stdio.in modport)
//  stdin.data   in   16  word to transmit
//  stdin.rdy    out  1   block can accept a word this cycle
//  tx_o         out  1   UART serial line, idle high
//  busy_o       out  1   frame transmission in progress
// BEHAVIOUR
//  Reset: any posedge with rst_ni=0 -> state IDLE, tx_o=1, busy_o=0, counters 0;
//   stdin.rdy=0 while rst_ni=0 (no handshake accepted); effective from the next cycle.
//  Reset mid-frame: frame aborted, word discarded, tx_o=1 next cycle (truncated frame on line is acceptable).
//  Handshake: stdin.rdy = rst_ni && (state==IDLE), combinational from state; word accepted on a
//   posedge with val && rdy; data latched into a 16-bit shift register only then; later
//   changes of stdin.data or val are ignored until the block returns to IDLE.
//  val may rise or fall at any time; no acceptance while rdy=0; no combinational val->rdy path.
//  FSM states: IDLE, START, DATA, STOP; byte_sel 0/1 (0 = high byte data[15:8], 1 = low byte data[7:0]).
//   IDLE : tx_o=1; on accept -> START, byte_sel=0, bit counter cleared.
//   START: tx_o=0 for CLKS_PER_BIT cycles -> DATA, bit index 0.
//   DATA : tx_o = current byte bit[idx], LSB first, each held CLKS_PER_BIT cycles; after idx 7 -> STOP.
//   STOP : tx_o=1 for CLKS_PER_BIT cycles; then byte_sel=0 -> START with byte_sel=1
//          (no idle gap between the two frames); byte_sel=1 -> IDLE.
//  tx_o and busy_o are registered; busy_o = (state != IDLE).
//  Latency: accept on edge E -> tx_o=0 and busy_o=1 in the cycle after E.
//   Word occupies exactly 20*CLKS_PER_BIT cycles on the line; rdy=1 again in the cycle
//   immediately after the final stop bit; minimum accept-to-accept spacing 20*CLKS_PER_BIT+1 cycles.
//  Widths: baud counter $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1, then wraps to 0 and
//   advances the bit; bit index 3 bits; no arithmetic overflow is possible by construction.
//  Data values are transmitted verbatim, including 16'h0000 and 16'hFFFF (no escaping, no parity).
// TESTING (CLKS_PER_BIT=4 unless noted)
//  1 Hold rst_ni=0 3 cycles with val=1 -> no accept, tx_o=1, busy_o=0, rdy=0; release -> rdy=1 next cycle.
//  2 Send 16'hA55A -> tx_o: 0 | 1,0,1,0,0,1,0,1 | 1 | 0 | 0,1,0,1,1,0,1,0 | 1, each bit 4 cycles,
//    80 cycles total, busy_o=1 throughout; rdy=1 in cycle 81.
//  3 val held high with 16'h0001 then 16'hFFFF, data changed mid-frame -> second word accepted
//    exactly 81 cycles after first; first frame pair still carries 0x00,0x01.
//  4 Pulse val while busy_o=1 -> rdy=0, no accept, transmitted bits unchanged.
//  5 Assert rst_ni=0 at cycle 30 of a frame -> tx_o=1, busy_o=0 next cycle; next word 16'h1234
//    transmitted cleanly as 0x12 then 0x34.
//  6 CLKS_PER_BIT=434, send 16'h0000 and 16'hFFFF -> UART monitor at 115200 baud decodes
//    bytes 00,00,FF,FF with valid start/stop bits, no framing errors.

Source files
------------

// File: rtl/stdio_uart_tx_if.sv
// stdio val/rdy word stream between a producer and a sink.
// Producer drives val/data, sink answers with rdy.
interface stdio_if;
  logic        val;
  logic        rdy;
  logic [15:0] data;

  modport in  (input val, input data, output rdy);
  modport out (output val, output data, input rdy);
endinterface

// File: rtl/stdio_uart_tx.sv
// stdio sink: each accepted 16-bit word leaves tx_o as two 8N1 frames.
// High byte first, LSB first within a byte, frames back to back.
module stdio_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk_i,
  input  logic rst_ni,
  stdio_if.in  stdin,
  output logic tx_o,
  output logic busy_o
);

  if (CLKS_PER_BIT < 2) begin : g_bad_param
    $error("stdio_uart_tx: CLKS_PER_BIT must be >= 2");
  end

  localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic          r_sel;
  logic [15:0]   r_shreg;
  logic          r_tx;
  logic          r_busy;

  logic          w_wrap;
  logic [7:0]    w_byte;
  logic [2:0]    w_nidx;
  logic [CW-1:0] w_cnt_inc;

  assign w_wrap    = (r_cnt == LAST);
  assign w_byte    = r_sel ? r_shreg[7:0] : r_shreg[15:8];
  assign w_nidx    = r_idx + 3'd1;
  assign w_cnt_inc = r_cnt + CW'(1);

  assign stdin.rdy = rst_ni && (r_state == IDLE);
  assign tx_o      = r_tx;
  assign busy_o    = r_busy;

  // Frame FSM: bit-period counter, bit index, byte select, line driver.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sel   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (stdin.val) begin
            r_state <= START;
            r_cnt   <= '0;
            r_sel   <= 1'b0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_wrap) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= DATA;
            r_tx    <= w_byte[0];
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        DATA: begin
          if (w_wrap) begin
            r_cnt <= '0;
            if (r_idx == 3'd7) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_idx <= w_nidx;
              r_tx  <= w_byte[w_nidx];
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        STOP: begin
          if (w_wrap) begin
            r_cnt <= '0;
            if (!r_sel) begin
              r_state <= START;
              r_sel   <= 1'b1;
              r_tx    <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Word register: loaded only on an accepted handshake.
  always_ff @(posedge clk_i) begin
    if (stdin.rdy && stdin.val) begin
      r_shreg <= stdin.data;
    end
  end

endmodule
